dial_dir_tracker: RTL and testbench
===================================

// Module: dial_dir_tracker
// PURPOSE
//  Parametrised successor to the safe's direction decoder. Samples the vault dial code, classifies
//  each sample as +1/-1/hold/jump with modulo wrap, and tracks rotation direction with hysteresis.
//  Also provides a direction-change pulse, a per-direction step count and a jump error.
//  Sits between the dial encoder and the combination checker FSM.
// PARAMETERS
//  CODE_W  5  dial code width; dial has 2**CODE_W positions
//  HYST    2  consecutive opposite steps needed to flip direction (1 = legacy immediate flip; legal >=1)
//  CNT_W   8  width of step_count (and rev_count)
// PORTS
//  clock       in   1       system clock, rising edge
//  n_reset     in   1       asynchronous active-low reset
//  vault_code  in   CODE_W  current dial position
//  code_valid  in   1       vault_code is sampled only in cycles where this is 1
//  direction   out  1       1 = clockwise (incrementing code), 0 = anticlockwise
//  dir_change  out  1       one-cycle pulse when direction flips
//  step_count  out  CNT_W   steps taken in current direction, saturating
//  jump_err    out  1       one-cycle pulse: sampled code moved by more than one position
//  rev_count   out  CNT_W   only with DIAL_REV_COUNT_EN: full revolutions in current direction
// BEHAVIOUR
//  - Reset (async, n_reset=0):
//    - state=UNPRIMED, direction=1, dir_change=0, step_count=0, jump_err=0, pend=0, rev_count=0.
//  - All outputs are registered. Response appears the cycle after the sampling edge (1-cycle latency).
//  - code_valid=0: no state change; dir_change and jump_err deassert.
//  - UNPRIMED: first valid sample loads prev_code -> state CW; no step, no pulse.
//  - Classification: delta = (vault_code - prev_code) mod 2**CODE_W.
//    - 1 = UP; all-ones = DOWN; 0 = HOLD; else JUMP.
//    - Wrap is seamless: 31->0 is UP, 0->31 is DOWN (CODE_W=5).
//  - prev_code <= vault_code on every valid sample after priming.
//  - States CW / ACW; direction = (state==CW). Same-direction step: pend<=0, step_count +1 (sat at 2**CNT_W-1).
//  - Opposite step:
//    - If pend==HYST-1: flip state, dir_change=1, step_count<=HYST, pend<=0.
//    - Otherwise: pend+1, step_count unchanged.
//  - HOLD: nothing changes (pend retained).
//  - JUMP: jump_err=1, pend<=0, state/step_count unchanged.
//  - Reset mid-rotation returns to UNPRIMED. Next sample re-primes and does not count as a step.
// CONFIGURATION
//  DIAL_REV_COUNT_EN defined:
//    - rev_count port exists.
//    - Internal position counter increments per same-direction step.
//    - On reaching 2**CODE_W, the position counter clears and rev_count increments (saturating).
//    - Flip or JUMP clears both the position counter and rev_count.
//  DIAL_REV_COUNT_EN undefined: rev_count port and counters absent; all other behaviour identical.
// STRUCTURE
//  - Package dial_pkg:
//    - typedef enum logic[1:0] {UNPRIMED,CW,ACW} dial_state_t
//    - typedef enum logic[1:0] {STEP_HOLD,STEP_UP,STEP_DOWN,STEP_JUMP} step_t
//    - DIR_CW=1'b1, DIR_ACW=1'b0
//  - Sub-module dial_step_classifier: combinational (prev_code, vault_code) -> step_t, parametrised CODE_W.
//  - Top holds prev_code, FSM, pend counter, step/rev counters.
// TESTING
//  - Reset then valid 5,6,7 -> direction=1, step_count=2, no pulses; dir_change never set on priming sample.
//  - HYST=2, CW at 10: samples 9 -> no flip, pend=1; then 8 -> dir_change=1 one cycle, direction=0, step_count=2.
//  - HYST=2, CW at 10: samples 9,10 -> no flip; pend cleared, step_count +1.
//  - Wrap at CODE_W=5: 30,31,0,1 -> three UP steps, no jump_err; 1,0,31 in ACW -> two DOWN steps.
//  - Jump: 4 then 9 -> jump_err=1 one cycle, direction/step_count unchanged, pend=0.
//  - code_valid=0 for 5 cycles with changing code -> outputs frozen.
//  - n_reset low mid-sequence -> all outputs 0 / direction=1 immediately (async), no clock needed.
//  - DIAL_REV_COUNT_EN, CODE_W=5: 32 consecutive UP steps -> rev_count=1.
//  - DIAL_REV_COUNT_EN: flip after 40 UP steps -> rev_count=0.
//  - step_count saturation: CNT_W=4, 20 UP steps -> step_count=15.

Source files
------------

// File: rtl/dial_dir_tracker_pkg.sv
// dial_dir_tracker_pkg: shared types and constants for the dial direction tracker.
// Contents: dial_state_t (tracker FSM states), step_t (sample classification),
//           DIR_CW / DIR_ACW (encoding of the direction output).
package dial_pkg;
    typedef enum logic [1:0] {UNPRIMED, CW, ACW} dial_state_t;
    typedef enum logic [1:0] {STEP_HOLD, STEP_UP, STEP_DOWN, STEP_JUMP} step_t;
    localparam logic DIR_CW  = 1'b1;
    localparam logic DIR_ACW = 1'b0;
endpackage

// File: rtl/dial_dir_tracker_classifier.sv
// dial_step_classifier: classifies the move from prev_code_i to vault_code_i on a modulo-2**CODE_W dial.
// Ports: prev_code_i  - last sampled dial position
//        vault_code_i - current dial position
//        step_o       - STEP_HOLD / STEP_UP / STEP_DOWN / STEP_JUMP
module dial_step_classifier
    import dial_pkg::*;
#(
    parameter int CODE_W = 5
) (
    input  logic [CODE_W-1:0] prev_code_i,
    input  logic [CODE_W-1:0] vault_code_i,
    output step_t             step_o
);
    logic [CODE_W-1:0] delta;

    // Modulo subtraction makes the 31->0 / 0->31 wrap fall out as +1 / -1.
    assign delta = vault_code_i - prev_code_i;

    always_comb begin
        step_o = delta == '0             ? STEP_HOLD :
                 delta == CODE_W'(1)     ? STEP_UP   :
                 delta == {CODE_W{1'b1}} ? STEP_DOWN : STEP_JUMP;
    end
endmodule

// File: rtl/dial_dir_tracker.sv
// dial_dir_tracker: tracks dial rotation direction with hysteresis, step count and jump detection.
// Ports: clock, n_reset (async active-low)
//        vault_code, code_valid - dial position and its sample qualifier
//        direction  - 1 clockwise, 0 anticlockwise
//        dir_change - one-cycle pulse on a direction flip
//        step_count - saturating steps in the current direction
//        jump_err   - one-cycle pulse when the dial moved by more than one position
//        rev_count  - full revolutions in the current direction (only with DIAL_REV_COUNT_EN)
// Build option: define DIAL_REV_COUNT_EN to add the revolution counter and rev_count port.
module dial_dir_tracker
    import dial_pkg::*;
#(
    parameter int CODE_W = 5,
    parameter int HYST   = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clock,
    input  logic              n_reset,
    input  logic [CODE_W-1:0] vault_code,
    input  logic              code_valid,
    output logic              direction,
    output logic              dir_change,
    output logic [CNT_W-1:0]  step_count,
    output logic              jump_err
`ifdef DIAL_REV_COUNT_EN
    ,
    output logic [CNT_W-1:0]  rev_count
`endif
);
    localparam int PEND_W = HYST > 1 ? $clog2(HYST) : 1;
    localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(HYST - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    dial_state_t       state_q, state_d;
    logic [CODE_W-1:0] prev_q, prev_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic [CNT_W-1:0]  step_q, step_d;
    logic              dc_q, dc_d;
    logic              je_q, je_d;
    step_t             step;
    logic              same, opp, flip;

    dial_step_classifier #(.CODE_W(CODE_W)) u_cls (
        .prev_code_i  (prev_q),
        .vault_code_i (vault_code),
        .step_o       (step)
    );

    // same/opp are relative to the current direction; flip is an opposite step that completes the hysteresis.
    always_comb begin
        same = (state_q == CW && step == STEP_UP) || (state_q == ACW && step == STEP_DOWN);
        opp  = (state_q == CW && step == STEP_DOWN) || (state_q == ACW && step == STEP_UP);
        flip = opp && pend_q == PEND_MAX;
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= UNPRIMED;
            prev_q  <= '0;
            pend_q  <= '0;
            step_q  <= '0;
            dc_q    <= 1'b0;
            je_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            pend_q  <= pend_d;
            step_q  <= step_d;
            dc_q    <= dc_d;
            je_q    <= je_d;
        end
    end

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        pend_d  = pend_q;
        step_d  = step_q;
        dc_d    = 1'b0;
        je_d    = 1'b0;
        if (code_valid) begin
            prev_d = vault_code;
            if (state_q == UNPRIMED) begin
                state_d = CW;
            end else if (step == STEP_JUMP) begin
                je_d   = 1'b1;
                pend_d = '0;
            end else if (same) begin
                pend_d = '0;
                step_d = step_q == CNT_MAX ? step_q : step_q + 1'b1;
            end else if (flip) begin
                state_d = state_q == CW ? ACW : CW;
                dc_d    = 1'b1;
                // The HYST opposite steps that caused the flip count toward the new direction.
                step_d  = CNT_W'(HYST);
                pend_d  = '0;
            end else if (opp) begin
                pend_d = pend_q + 1'b1;
            end
        end
    end

    always_comb begin
        direction  = state_q == ACW ? DIR_ACW : DIR_CW;
        dir_change = dc_q;
        step_count = step_q;
        jump_err   = je_q;
    end

`ifdef DIAL_REV_COUNT_EN
    logic [CODE_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0]  rev_q, rev_d;

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            pos_q <= '0;
            rev_q <= '0;
        end else begin
            pos_q <= pos_d;
            rev_q <= rev_d;
        end
    end

    // pos counts modulo 2**CODE_W; its wrap marks one full revolution.
    always_comb begin
        pos_d = pos_q;
        rev_d = rev_q;
        if (code_valid && state_q != UNPRIMED) begin
            if (step == STEP_JUMP || flip) begin
                pos_d = '0;
                rev_d = '0;
            end else if (same) begin
                pos_d = pos_q + 1'b1;
                if (pos_q == {CODE_W{1'b1}})
                    rev_d = rev_q == CNT_MAX ? rev_q : rev_q + 1'b1;
            end
        end
    end

    assign rev_count = rev_q;
`endif
endmodule

// File: tb/tb_dial_dir_tracker.sv
// tb_dial_dir_tracker: directed self-checking bench for dial_dir_tracker (CODE_W=5, HYST=2, CNT_W=4).
module tb_dial_dir_tracker;
    logic       clock = 1'b0;
    logic       n_reset = 1'b0;
    logic [4:0] vault_code = '0;
    logic       code_valid = 1'b0;
    logic       direction, dir_change, jump_err;
    logic [3:0] step_count;
`ifdef DIAL_REV_COUNT_EN
    logic [3:0] rev_count;
`endif
    int errors = 0;
    int checks = 0;

    dial_dir_tracker #(.CODE_W(5), .HYST(2), .CNT_W(4)) dut (
        .clock      (clock),
        .n_reset    (n_reset),
        .vault_code (vault_code),
        .code_valid (code_valid),
        .direction  (direction),
        .dir_change (dir_change),
        .step_count (step_count),
        .jump_err   (jump_err)
`ifdef DIAL_REV_COUNT_EN
        ,
        .rev_count  (rev_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic smp(input logic [4:0] code, input logic v);
        vault_code = code;
        code_valid = v;
        @(posedge clock);
        #1;
    endtask

    task automatic st(input string tag, input logic d, input logic dc, input logic [3:0] s, input logic je);
        chk({tag, ".dir"}, 32'(direction), 32'(d));
        chk({tag, ".dc"}, 32'(dir_change), 32'(dc));
        chk({tag, ".step"}, 32'(step_count), 32'(s));
        chk({tag, ".je"}, 32'(jump_err), 32'(je));
    endtask

    initial begin
        #2;
        st("reset", 1, 0, 0, 0);
        @(negedge clock);
        n_reset = 1'b1;
        smp(5, 1); st("prime5", 1, 0, 0, 0);
        smp(6, 1); st("up6", 1, 0, 1, 0);
        smp(7, 1); st("up7", 1, 0, 2, 0);
        smp(8, 1); smp(9, 1); smp(10, 1); st("up10", 1, 0, 5, 0);
        smp(9, 1); st("pend9", 1, 0, 5, 0);
        smp(10, 1); st("cancel10", 1, 0, 6, 0);
        smp(9, 1); st("pend9b", 1, 0, 6, 0);
        smp(8, 1); st("flip8", 0, 1, 2, 0);
        smp(8, 1); st("hold8", 0, 0, 2, 0);
        smp(1, 1); st("jump1", 0, 0, 2, 1);
        smp(0, 1); st("down0", 0, 0, 3, 0);
        smp(31, 1); st("wrap31", 0, 0, 4, 0);
        smp(30, 1); st("down30", 0, 0, 5, 0);
        smp(31, 1); st("pend31", 0, 0, 5, 0);
        smp(4, 1); st("jump4", 0, 0, 5, 1);
        smp(5, 1); st("pendclr5", 0, 0, 5, 0);
        smp(6, 1); st("flip6", 1, 1, 2, 0);
        for (int i = 0; i < 5; i++) begin
            smp(5'(7 + 3 * i), 0);
            st("frozen", 1, 0, 2, 0);
        end
        smp(30, 1); st("jump30", 1, 0, 2, 1);
        smp(31, 1); st("up31", 1, 0, 3, 0);
        smp(0, 1); st("wrap0", 1, 0, 4, 0);
        smp(1, 1); st("up1", 1, 0, 5, 0);
        for (int i = 2; i <= 11; i++) smp(5'(i), 1);
        st("sat_reach", 1, 0, 15, 0);
        for (int i = 12; i <= 17; i++) smp(5'(i), 1);
        st("sat_hold", 1, 0, 15, 0);
        smp(16, 1); st("pend16", 1, 0, 15, 0);
        smp(15, 1); st("flip15", 0, 1, 2, 0);
        #2;
        n_reset = 1'b0;
        #1;
        st("async_rst", 1, 0, 0, 0);
        @(negedge clock);
        n_reset = 1'b1;
        smp(3, 1); st("reprime3", 1, 0, 0, 0);
        smp(4, 1); st("after_reprime", 1, 0, 1, 0);
`ifdef DIAL_REV_COUNT_EN
        #2;
        n_reset = 1'b0;
        @(negedge clock);
        n_reset = 1'b1;
        smp(0, 1);
        for (int i = 1; i <= 31; i++) smp(5'(i), 1);
        chk("rev31", 32'(rev_count), 0);
        smp(0, 1);
        chk("rev32", 32'(rev_count), 1);
        for (int i = 1; i <= 8; i++) smp(5'(i), 1);
        chk("rev40", 32'(rev_count), 1);
        smp(7, 1);
        chk("rev_pend", 32'(rev_count), 1);
        smp(6, 1);
        chk("rev_flip", 32'(rev_count), 0);
        chk("rev_flip.dir", 32'(direction), 0);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
